// File: rtl/stat_display_sched.sv
// Display-bus scheduler: auto-rotates, manually selects or lets syscall output pre-empt
// the board display, and freezes a snapshot of all sources once the core halts.
module stat_display_sched #(
   parameter int DWELL = 1000,
   parameter int HOLD  = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] total_cycles,
   input  logic [31:0] uncondi_num,
   input  logic [31:0] condi_num,
   input  logic [31:0] condi_suc_num,
   input  logic [31:0] SyscallOut,
   input  logic        syscall_valid,
   input  logic        halt,
   input  logic        auto_en,
   input  logic [2:0]  sel,
   input  logic        next,
   output logic [31:0] disp_data,
   output logic [2:0]  disp_src,
   output logic        frozen
);
   localparam int NSRC = 5;
   localparam int DW   = $clog2(DWELL);
   localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
   localparam logic [2:0]    SYS_IDX    = 3'd4;

   typedef enum logic [1:0] {AUTO, MANUAL, SYS_HOLD, HALTED} state_t;

   state_t                 state, state_n;
   logic [2:0]             idx, idx_n, saved_idx, saved_idx_n;
   logic [DW-1:0]          dwell_cnt, dwell_n;
   logic [HW-1:0]          hold_cnt, hold_n;
   logic                   snap_ld;
   logic [NSRC-1:0][31:0]  src, snap;

   assign src    = {SyscallOut, condi_suc_num, condi_num, uncondi_num, total_cycles};
   assign frozen = (state == HALTED);

   function automatic logic [2:0] clamp_sel(input logic [2:0] s);
      return (s > SYS_IDX) ? SYS_IDX : s;
   endfunction

   function automatic logic [2:0] step_idx(input logic [2:0] i);
      return (i >= SYS_IDX) ? 3'd0 : i + 3'd1;
   endfunction

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      saved_idx_n = saved_idx;
      dwell_n     = dwell_cnt;
      hold_n      = hold_cnt;
      snap_ld     = 1'b0;
      if (halt && state != HALTED) begin
         state_n = HALTED;
         snap_ld = 1'b1;
         dwell_n = '0;
      end else begin
         case (state)
            AUTO: begin
               if (syscall_valid) begin
                  state_n     = SYS_HOLD;
                  saved_idx_n = idx;
                  idx_n       = SYS_IDX;
                  hold_n      = '0;
               end else if (next || dwell_cnt == DWELL_LAST) begin
                  idx_n   = step_idx(idx);
                  dwell_n = '0;
               end else if (!auto_en) begin
                  state_n = MANUAL;
               end else begin
                  dwell_n = dwell_cnt + 1'b1;
               end
            end
            MANUAL: begin
               if (syscall_valid) begin
                  state_n     = SYS_HOLD;
                  saved_idx_n = idx;
                  idx_n       = SYS_IDX;
                  hold_n      = '0;
               end else if (auto_en) begin
                  state_n = AUTO;
                  dwell_n = '0;
               end else begin
                  idx_n = clamp_sel(sel);
               end
            end
            SYS_HOLD: begin
               // a repeated syscall only restarts the hold; the return point stays put
               if (syscall_valid) begin
                  hold_n = '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  idx_n   = saved_idx;
                  state_n = auto_en ? AUTO : MANUAL;
                  dwell_n = '0;
               end else begin
                  hold_n = hold_cnt + 1'b1;
               end
            end
            HALTED: begin
               if (!auto_en) begin
                  idx_n   = clamp_sel(sel);
                  dwell_n = '0;
               end else if (dwell_cnt == DWELL_LAST) begin
                  idx_n   = step_idx(idx);
                  dwell_n = '0;
               end else begin
                  dwell_n = dwell_cnt + 1'b1;
               end
            end
            default: state_n = AUTO;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= AUTO;
         idx       <= '0;
         saved_idx <= '0;
         dwell_cnt <= '0;
         hold_cnt  <= '0;
         snap      <= '0;
         disp_data <= '0;
         disp_src  <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         saved_idx <= saved_idx_n;
         dwell_cnt <= dwell_n;
         hold_cnt  <= hold_n;
         if (snap_ld) snap <= src;
         disp_src  <= idx;
         disp_data <= (state == HALTED) ? snap[idx] : src[idx];
      end
   end
endmodule

// File: tb/tb_stat_display_sched.sv
// Scoreboard bench for stat_display_sched: the driver queues the expected display per
// cycle, the monitor compares on each falling edge (or on demand for async reset checks).
module tb_stat_display_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] total_cycles, uncondi_num, condi_num, condi_suc_num, SyscallOut;
   logic        syscall_valid, halt, auto_en, next;
   logic [2:0]  sel;
   logic [31:0] disp_data;
   logic [2:0]  disp_src;
   logic        frozen;

   typedef struct {
      int         tcyc;
      int         tag;
      logic [2:0] src;
      logic [31:0] data;
      logic       frz;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;
   event wake_ev;

   stat_display_sched #(.DWELL(4), .HOLD(3)) dut (
      .clk(clk), .rst(rst),
      .total_cycles(total_cycles), .uncondi_num(uncondi_num), .condi_num(condi_num),
      .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
      .syscall_valid(syscall_valid), .halt(halt), .auto_en(auto_en),
      .sel(sel), .next(next),
      .disp_data(disp_data), .disp_src(disp_src), .frozen(frozen)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // d > 0: check at the falling edge d cycles from now; d < 0: check on the next wake event
   task automatic exp(input int d, input int tag, input logic [2:0] s, input logic [31:0] v,
                      input logic f);
      exp_t e;
      e.tcyc = (d < 0) ? -1 : cyc + d;
      e.tag  = tag;
      e.src  = s;
      e.data = v;
      e.frz  = f;
      sbq.push_back(e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      forever begin
         @(negedge clk or wake_ev);
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].tcyc == cyc || sbq[i].tcyc < 0) begin
               checks++;
               if (disp_src !== sbq[i].src || disp_data !== sbq[i].data || frozen !== sbq[i].frz) begin
                  errors++;
                  $display("FAIL t%0d_cyc%0d: got src=%0d data=%h frozen=%b, expected src=%0d data=%h frozen=%b",
                           sbq[i].tag, cyc, disp_src, disp_data, frozen,
                           sbq[i].src, sbq[i].data, sbq[i].frz);
               end
               sbq.delete(i);
            end
         end
         if (done) begin
            checks++;
            if (sbq.size() != 0) begin
               errors++;
               $display("FAIL pending: %0d expectations left unchecked, expected 0", sbq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; auto_en = 1'b1; sel = 3'd0; next = 1'b0; halt = 1'b0; syscall_valid = 1'b0;
      total_cycles = 32'd10; uncondi_num = 32'd11; condi_num = 32'd12;
      condi_suc_num = 32'd13; SyscallOut = 32'd14;
      #1;
      exp(-1, 0, 3'd0, 32'd0, 1'b0);
      ->wake_ev;
      @(negedge clk);
      exp(1, 0, 3'd0, 32'd0, 1'b0);
      @(negedge clk);

      // 1: auto rotation, 4 cycles per source; 2: next at idx=2, dwell_cnt=1
      rst = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         logic [2:0] s;
         s = 3'(((k - 1) / 4) % 5);
         exp(k, 1, s, 32'(10) + 32'(s), 1'b0);
      end
      for (int k = 25; k <= 28; k++) exp(k, 2, 3'd1, 32'd11, 1'b0);
      for (int k = 29; k <= 30; k++) exp(k, 2, 3'd2, 32'd12, 1'b0);
      for (int k = 31; k <= 34; k++) exp(k, 2, 3'd3, 32'd13, 1'b0);
      exp(35, 2, 3'd4, 32'd14, 1'b0);
      wait_n(29); next = 1'b1;
      wait_n(1);  next = 1'b0;
      wait_n(5);

      // 3: manual select with out-of-range sel, then sel change
      auto_en = 1'b0; sel = 3'd6;
      for (int k = 1; k <= 4; k++) exp(k, 3, 3'd4, 32'd14, 1'b0);
      exp(5, 3, 3'd1, 32'd11, 1'b0);
      exp(6, 3, 3'd1, 32'd11, 1'b0);
      wait_n(3); sel = 3'd1;
      wait_n(3);

      // 4: syscall pre-emption in manual mode, then an extended hold
      sel = 3'd2;
      exp(1, 4, 3'd1, 32'd11, 1'b0);
      exp(2, 4, 3'd2, 32'd12, 1'b0);
      for (int k = 3; k <= 5; k++) exp(k, 4, 3'd4, 32'h55, 1'b0);
      exp(6, 4, 3'd2, 32'd12, 1'b0);
      exp(7, 4, 3'd2, 32'd12, 1'b0);
      exp(8, 4, 3'd4, 32'h55, 1'b0);
      exp(9, 4, 3'd4, 32'h55, 1'b0);
      for (int k = 10; k <= 13; k++) exp(k, 4, 3'd4, 32'h66, 1'b0);
      exp(14, 4, 3'd2, 32'd12, 1'b0);
      wait_n(1); syscall_valid = 1'b1; SyscallOut = 32'h55;
      wait_n(1); syscall_valid = 1'b0;
      wait_n(4); syscall_valid = 1'b1;
      wait_n(1); syscall_valid = 1'b0;
      wait_n(2); syscall_valid = 1'b1; SyscallOut = 32'h66;
      wait_n(1); syscall_valid = 1'b0;
      wait_n(4);

      // 5: halt together with syscall; snapshot shown, live inputs ignored
      auto_en = 1'b1; total_cycles = 32'h100;
      exp(1, 5, 3'd2, 32'd12, 1'b0);
      exp(2, 5, 3'd2, 32'd12, 1'b0);
      exp(3, 5, 3'd2, 32'd12, 1'b1);
      exp(4, 5, 3'd2, 32'd12, 1'b1);
      for (int k = 5; k <= 7; k++) exp(k, 5, 3'd4, 32'h77, 1'b1);
      exp(8, 5, 3'd0, 32'h100, 1'b1);
      exp(9, 5, 3'd0, 32'h100, 1'b1);
      wait_n(2); halt = 1'b1; syscall_valid = 1'b1; SyscallOut = 32'h77;
      wait_n(1); syscall_valid = 1'b0; total_cycles = 32'h200; SyscallOut = 32'h88;
      condi_num = 32'h99; auto_en = 1'b0; sel = 3'd4;
      wait_n(3); sel = 3'd0;
      wait_n(3);

      // 6a: asynchronous reset while halted
      #2 rst = 1'b0;
      #1 exp(-1, 6, 3'd0, 32'd0, 1'b0);
      ->wake_ev;
      halt = 1'b0; auto_en = 1'b1; sel = 3'd0;
      total_cycles = 32'd10; SyscallOut = 32'd14; condi_num = 32'd12;
      exp(1, 6, 3'd0, 32'd0, 1'b0);
      wait_n(1);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) exp(k, 7, 3'd0, 32'd10, 1'b0);
      exp(5, 7, 3'd1, 32'd11, 1'b0);
      wait_n(5);

      // 6b: asynchronous reset during a syscall hold
      syscall_valid = 1'b1; SyscallOut = 32'h42;
      exp(1, 8, 3'd1, 32'd11, 1'b0);
      exp(2, 8, 3'd4, 32'h42, 1'b0);
      wait_n(1); syscall_valid = 1'b0;
      wait_n(1);
      #2 rst = 1'b0;
      #1 exp(-1, 9, 3'd0, 32'd0, 1'b0);
      ->wake_ev;
      exp(1, 9, 3'd0, 32'd0, 1'b0);
      wait_n(1);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) exp(k, 10, 3'd0, 32'd10, 1'b0);
      exp(5, 10, 3'd1, 32'd11, 1'b0);
      wait_n(6);
      done = 1'b1;
      #1 ->wake_ev;
   end
endmodule
